// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder.
// - register window offsets (low address byte)
// - STATUS register bit positions
// - response struct and byte-enable merge helper
package mmio_responder_pkg;

  localparam logic [7:0] MMIO_TXDATA      = 8'h00;
  localparam logic [7:0] MMIO_STATUS      = 8'h04;
  localparam logic [7:0] MMIO_MTIME_LO    = 8'h08;
  localparam logic [7:0] MMIO_MTIME_HI    = 8'h0C;
  localparam logic [7:0] MMIO_MTIMECMP_LO = 8'h10;
  localparam logic [7:0] MMIO_MTIMECMP_HI = 8'h14;
  localparam logic [7:0] MMIO_EXIT        = 8'h18;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        error;
  } mmio_rsp_t;

  // Replace only the enabled bytes of old with the matching bytes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/mmio_responder_sync_fifo.sv
// Synchronous FIFO with registered head (rdata/rvalid).
// Ports: push/wdata write side (ignored when full), ready pops the head
// when rvalid, full/empty/count reflect current occupancy.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ready,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, nxt_rd;
  logic [CW-1:0]    nxt_cnt;
  logic [WIDTH-1:0] head;
  logic             do_push, do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = rvalid && ready;

  // Next head: bypass the incoming byte when it lands in the slot that
  // becomes the head (push into an empty or just-drained FIFO).
  always_comb begin
    nxt_rd  = rd_ptr + AW'(do_pop);
    nxt_cnt = count + CW'(do_push) - CW'(do_pop);
    head    = (do_push && wr_ptr == nxt_rd) ? wdata : mem[nxt_rd];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rd_ptr <= nxt_rd;
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= nxt_cnt;
      rvalid <= nxt_cnt != '0;
      if (nxt_cnt != '0) rdata <= head;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target on the CPU data port: console TX FIFO, 64-bit machine timer
// with compare interrupt, and a simulation exit register.
// Ports: req_* request channel (valid/ready), rsp_* one-cycle response,
// tx_* console byte stream, timer_irq, halt/exit_code.
module mmio_responder import mmio_responder_pkg::*; #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  timer_irq,
  output logic                  halt,
  output logic [31:0]           exit_code
);
  logic [7:0]            off;
  logic                  acc, wr, push, mapped;
  logic [31:0]           rd_val;
  logic [63:0]           mtime, mtimecmp;
  mmio_rsp_t             rsp;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  unused_addr;

  assign off         = req_addr[7:0];
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:8];

  // Only a byte-0 TXDATA store into a full FIFO stalls; rst gates ready low
  // while reset is held.
  assign req_ready = rst && !halt &&
                     !(req_write && off == MMIO_TXDATA && req_wstrb[0] && fifo_full);
  assign acc  = req_valid && req_ready;
  assign wr   = acc && req_write;
  assign push = wr && off == MMIO_TXDATA && req_wstrb[0];

  // Every mapped offset has addr[1:0]==0, so misaligned addresses fall to default.
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (off)
      MMIO_TXDATA: rd_val = '0;
      MMIO_STATUS: begin
        rd_val[ST_FULL]                        = fifo_full;
        rd_val[ST_EMPTY]                       = fifo_empty;
        rd_val[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
      end
      MMIO_MTIME_LO:    rd_val = mtime[31:0];
      MMIO_MTIME_HI:    rd_val = mtime[63:32];
      MMIO_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      MMIO_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      MMIO_EXIT:        rd_val = exit_code;
      default:          mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      halt      <= 1'b0;
      exit_code <= '0;
      timer_irq <= 1'b0;
      rsp       <= '0;
    end else begin
      if (!halt) begin
        // A half being written takes the store value instead of counting;
        // a lo write also drops that cycle's carry into hi.
        if (wr && off == MMIO_MTIME_LO)
          mtime[31:0] <= merge_bytes(mtime[31:0], req_wdata, req_wstrb);
        else if (wr && off == MMIO_MTIME_HI) begin
          mtime[63:32] <= merge_bytes(mtime[63:32], req_wdata, req_wstrb);
          mtime[31:0]  <= mtime[31:0] + 32'd1;
        end else
          mtime <= mtime + 64'd1;
      end
      if (wr && off == MMIO_MTIMECMP_LO)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], req_wdata, req_wstrb);
      if (wr && off == MMIO_MTIMECMP_HI)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], req_wdata, req_wstrb);
      if (wr && off == MMIO_EXIT) begin
        halt      <= 1'b1;
        exit_code <= req_wdata;
      end
      timer_irq <= mtime >= mtimecmp;
      rsp.valid <= acc;
      rsp.rdata <= (acc && !req_write && mapped) ? rd_val : '0;
      rsp.error <= acc && !mapped;
    end
  end

  assign rsp_valid = rsp.valid;
  assign rsp_rdata = rsp.rdata;
  assign rsp_error = rsp.error;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_txq (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wdata  (req_wdata[7:0]),
    .ready  (tx_ready),
    .rdata  (tx_data),
    .rvalid (tx_valid),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized + directed bench for mmio_responder against a transaction-level
// model: mtime as base+elapsed cycles, console FIFO as a byte queue.
module tb_mmio_responder;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_error, tx_valid, tx_ready, timer_irq, halt;
  logic [31:0] rsp_rdata, exit_code;
  logic [7:0]  tx_data;
  logic        rand_tx = 1'b0, tx_force = 1'b0, rnd_bit = 1'b0;

  int n_chk = 0, n_bad = 0, cyc = 0;

  // model state
  logic [63:0] mt_base, cmp_m;
  int          mt_bc;
  logic [31:0] exit_m;
  logic [7:0]  txq[$];

  assign tx_ready = rand_tx ? rnd_bit : tx_force;

  mmio_responder #(.DEPTH(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .timer_irq(timer_irq), .halt(halt), .exit_code(exit_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin #1; rnd_bit = 1'($urandom_range(0, 1)); end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // console sink scoreboard: bytes must leave in push order
  always @(posedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      if (txq.size() == 0) chk("tx_unexpected", {56'h0, tx_data}, 64'h1ff);
      else chk("tx_data", {56'h0, tx_data}, {56'h0, txq.pop_front()});
    end
  end

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mt_now(input int c);
    return mt_base + 64'(c - mt_bc);
  endfunction

  task automatic model_reset();
    txq.delete();
    cmp_m   = '1;
    exit_m  = '0;
    mt_base = '0;
    mt_bc   = cyc;
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string tag);
    logic acc = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [63:0] cur;
    int c;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1; else @(posedge clk);
    end
    if (!acc) begin
      chk({tag, "_stall"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    c = cyc;
    cur = mt_now(c);
    if (a[1:0] != 2'b00) exp_err = 1'b1;
    else case (a[7:0])
      8'h00: if (w && s[0]) txq.push_back(d[7:0]);
      8'h04: if (!w) exp_rd = {16'h0, 8'(txq.size()), 6'h0,
                               1'(txq.size() == 0), 1'(txq.size() == 8)};
      8'h08: if (w) begin mt_base = {cur[63:32], bmerge(cur[31:0], d, s)}; mt_bc = c + 1; end
             else exp_rd = cur[31:0];
      8'h0C: if (w) begin mt_base = {bmerge(cur[63:32], d, s), cur[31:0] + 32'd1}; mt_bc = c + 1; end
             else exp_rd = cur[63:32];
      8'h10: if (w) cmp_m[31:0] = bmerge(cmp_m[31:0], d, s); else exp_rd = cmp_m[31:0];
      8'h14: if (w) cmp_m[63:32] = bmerge(cmp_m[63:32], d, s); else exp_rd = cmp_m[63:32];
      8'h18: if (w) exit_m = d; else exp_rd = exit_m;
      default: exp_err = 1'b1;
    endcase
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    chk({tag, "_v"}, rsp_valid, 1);
    chk({tag, "_rd"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, rsp_error, exp_err);
  endtask

  task automatic drain(input string tag);
    tx_force = 1'b1;
    for (int i = 0; i < 100 && txq.size() != 0; i++) @(posedge clk);
    chk(tag, txq.size(), 0);
    @(posedge clk); #1;
    tx_force = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_outs", {rsp_valid, rsp_rdata, rsp_error, tx_valid, tx_data, timer_irq, halt, exit_code}, 0);
    @(negedge clk); rst = 1'b1; model_reset();
    @(posedge clk); #1;
    req(0, 32'h10, 0, 0, "cmplo_rst");
    req(0, 32'h14, 0, 0, "cmphi_rst");
    req(0, 32'h04, 0, 0, "status_rst");
    req(0, 32'h18, 0, 0, "exit_rst");
    chk("irq_rst", timer_irq, 0);
    @(posedge clk); #1;
    chk("rsp_pulse", rsp_valid, 0);
    // anchor the mtime model
    req(1, 32'h0C, 0, 4'hF, "mth0");
    req(1, 32'h08, 0, 4'hF, "mtl0");
    req(0, 32'h08, 0, 0, "mtl_rd");
    req(0, 32'h0C, 0, 0, "mth_rd");

    // three console bytes with the sink ready
    tx_force = 1'b1;
    for (int i = 0; i < 3; i++) req(1, 32'h00, 32'h41 + i, 4'h1, "tx3");
    repeat (3) @(posedge clk);
    #1;
    chk("tx3_drained", txq.size(), 0);
    req(0, 32'h04, 0, 0, "status_tx3");
    tx_force = 1'b0;

    // timer compare: irq after 20 increments plus one cycle of lag
    req(1, 32'h14, 0, 4'hF, "cmph");
    req(1, 32'h10, 20, 4'hF, "cmpl");
    req(1, 32'h08, 0, 4'hF, "mtl_irq");
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      chk($sformatf("irq_%0d", k), timer_irq, 64'(k >= 21));
    end

    // byte-enabled mtime writes and carry suppression
    req(1, 32'h08, 32'hFFFF_FFFF, 4'hF, "mtl_ones");
    req(1, 32'h08, 32'h0000_FFFF, 4'h3, "mtl_mask_c");
    req(0, 32'h0C, 0, 0, "mth_nocarry");
    req(0, 32'h08, 0, 0, "mtl_wrap");
    req(1, 32'h08, 32'h0000_FFFF, 4'h3, "mtl_mask");
    req(0, 32'h08, 0, 0, "mtl_mask_rd");
    req(0, 32'h0C, 0, 0, "mth_mask_rd");

    // unmapped / misaligned
    req(0, 32'h1C, 0, 0, "unmapped");
    req(0, 32'h06, 0, 0, "misaligned");
    req(1, 32'h11, 32'hDEAD_BEEF, 4'hF, "mis_store");
    req(0, 32'h10, 0, 0, "cmp_untouched");

    // randomized traffic
    rand_tx = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = $urandom();
      case ($urandom_range(0, 9))
        0: req(0, {a[31:8], 8'h08 + 8'(4 * $urandom_range(0, 1))}, 0, 0, "r_mt");
        1: req(1, {a[31:8], 8'h08 + 8'(4 * $urandom_range(0, 1))}, $urandom(), 4'($urandom()), "w_mt");
        2: req(0, {a[31:8], 8'h10 + 8'(4 * $urandom_range(0, 1))}, 0, 0, "r_cmp");
        3: req(1, {a[31:8], 8'h10 + 8'(4 * $urandom_range(0, 1))}, $urandom(), 4'($urandom()), "w_cmp");
        4: req(0, {a[31:8], 8'h04}, 0, 0, "r_status");
        5: req(1, {a[31:8], 8'h00}, $urandom(), 4'($urandom()), "w_tx");
        6: if (a[0]) req(a[1], {a[31:8], 8'h1C + 8'(4 * $urandom_range(0, 56))}, $urandom(), 4'hF, "r_unmap");
           else req(a[1], {a[31:8], 8'(4 * $urandom_range(0, 6) + $urandom_range(1, 3))}, $urandom(), 4'hF, "r_misal");
        7: req(a[2], {a[31:8], a[2] ? 8'h04 : 8'h00}, $urandom(), 4'hF, "r_misc");
        8: req(0, {a[31:8], 8'h18}, 0, 0, "r_exit");
        default: repeat ($urandom_range(0, 3)) @(posedge clk);
      endcase
    end
    rand_tx = 1'b0;
    drain("rand_drain");

    // FIFO full back-pressure
    for (int i = 0; i < 8; i++) req(1, 32'h00, 32'h60 + i, 4'h1, "fill");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h00; req_wdata = 32'h68; req_wstrb = 4'h1;
    @(negedge clk);
    chk("full_stall", req_ready, 0);
    tx_force = 1'b1;
    @(posedge clk); #1;
    tx_force = 1'b0;
    @(negedge clk);
    chk("full_after_pop", req_ready, 1);
    txq.push_back(8'h68);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ninth_rsp", rsp_valid, 1);
    req(0, 32'h04, 0, 0, "status_full");
    req(1, 32'h00, 32'h77, 4'h2, "tx_nostrb0_full");
    drain("full_drain");

    // reset mid-operation drops the in-flight response and the queued bytes
    req(1, 32'h00, 32'h55, 4'h1, "pre_rst");
    req(1, 32'h00, 32'h66, 4'h1, "pre_rst");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h04;
    @(posedge clk); #1;
    chk("inflight", rsp_valid, 1);
    rst = 1'b0;
    #1;
    req_valid = 1'b0;
    chk("rst_drop_rsp", rsp_valid, 0);
    chk("rst_drop_tx", tx_valid, 0);
    @(negedge clk); rst = 1'b1; model_reset();
    @(posedge clk); #1;
    req(0, 32'h04, 0, 0, "status_post_rst");

    // exit register: halt, stall forever, FIFO still drains
    for (int i = 0; i < 3; i++) req(1, 32'h00, 32'h30 + i, 4'h1, "pre_halt");
    req(1, 32'h18, 32'h2A, 4'h0, "exit");
    chk("halt", halt, 1);
    chk("exit_code", exit_code, 42);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h04;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_stall", req_ready, 0);
      chk("halt_norsp", rsp_valid, 64'(i == 0));
    end
    req_valid = 1'b0;
    drain("halt_drain");
    chk("halt_txv", tx_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
